// File: rtl/dmi_initiator.sv
`timescale 1ns/1ps
// Host-side DMI initiator: turns DTM dmi updates into single outstanding DMI
// requests, collects the responses and keeps a sticky error status.
module dmi_initiator #(
  parameter int unsigned TimeoutCycles = 0,
  parameter int unsigned CntWidth      = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        update_i,
  input  logic [6:0]  update_addr_i,
  input  logic [1:0]  update_op_i,
  input  logic [31:0] update_data_i,
  input  logic        dmireset_i,
  input  logic        dmihardreset_i,
  output logic [6:0]  capture_addr_o,
  output logic [31:0] capture_data_o,
  output logic [1:0]  capture_status_o,
  output logic        busy_o,
  output logic        dmi_req_valid_o,
  input  logic        dmi_req_ready_i,
  output logic [40:0] dmi_req_o,
  input  logic        dmi_resp_valid_i,
  output logic        dmi_resp_ready_o,
  input  logic [33:0] dmi_resp_i
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

  localparam bit                  TimeoutEn   = (TimeoutCycles != 0);
  localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(TimeoutCycles - 1);

  state_t              state_reg, state_next;
  logic [1:0]          sticky_reg, sticky_next;
  logic [CntWidth-1:0] cnt_reg, cnt_next;
  logic [40:0]         req_reg, req_next;
  logic [31:0]         capture_data_reg, capture_data_next;
  logic                cmd_valid;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg        <= ST_IDLE;
      sticky_reg       <= 2'd0;
      cnt_reg          <= '0;
      req_reg          <= '0;
      capture_data_reg <= '0;
    end else begin
      state_reg        <= state_next;
      sticky_reg       <= sticky_next;
      cnt_reg          <= cnt_next;
      req_reg          <= req_next;
      capture_data_reg <= capture_data_next;
    end
  end

  assign cmd_valid = update_i && (update_op_i == 2'd1 || update_op_i == 2'd2);

  always_comb begin
    state_next        = state_reg;
    sticky_next       = sticky_reg;
    cnt_next          = cnt_reg;
    req_next          = req_reg;
    capture_data_next = capture_data_reg;

    // Lowest-priority sticky source; a response or timeout below overrides it.
    if (update_i && state_reg != ST_IDLE && sticky_reg == 2'd0)
      sticky_next = 2'd3;

    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid && sticky_reg == 2'd0 && !dmireset_i) begin
          req_next   = {update_addr_i, update_data_i, update_op_i};
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (dmi_req_ready_i) begin
          state_next = ST_WAIT;
          cnt_next   = '0;
        end
      end
      ST_WAIT: begin
        if (cnt_reg != '1)
          cnt_next = cnt_reg + CntWidth'(1);
        if (dmi_resp_valid_i) begin
          capture_data_next = dmi_resp_i[33:2];
          // Codes 2 and 3 both have bit 1 set; 0 leaves sticky untouched.
          if (dmi_resp_i[1])
            sticky_next = dmi_resp_i[1:0];
          state_next = ST_IDLE;
        end else if (TimeoutEn && cnt_reg == TimeoutLast) begin
          sticky_next = 2'd2;
          state_next  = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (dmireset_i)
      sticky_next = 2'd0;

    if (dmihardreset_i) begin
      sticky_next       = 2'd0;
      state_next        = ST_IDLE;
      cnt_next          = '0;
      req_next          = req_reg;
      capture_data_next = capture_data_reg;
    end
  end

  assign busy_o           = (state_reg != ST_IDLE);
  assign dmi_req_valid_o  = (state_reg == ST_REQ);
  assign dmi_resp_ready_o = (state_reg != ST_REQ);
  assign dmi_req_o        = req_reg;
  assign capture_addr_o   = req_reg[40:34];
  assign capture_data_o   = capture_data_reg;
  assign capture_status_o = (sticky_reg != 2'd0) ? sticky_reg :
                            (busy_o ? 2'd3 : 2'd0);

endmodule

// File: tb/tb_dmi_initiator.sv
`timescale 1ns/1ps
// Scoreboard bench for dmi_initiator: stimulus pushes expected requests and
// completions, a negedge monitor pops and compares them as the DUT presents them.
module tb_dmi_initiator;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        update_i;
  logic [6:0]  update_addr_i;
  logic [1:0]  update_op_i;
  logic [31:0] update_data_i;
  logic        dmireset_i;
  logic        dmihardreset_i;
  logic [6:0]  capture_addr_o;
  logic [31:0] capture_data_o;
  logic [1:0]  capture_status_o;
  logic        busy_o;
  logic        dmi_req_valid_o;
  logic        dmi_req_ready_i;
  logic [40:0] dmi_req_o;
  logic        dmi_resp_valid_i;
  logic        dmi_resp_ready_o;
  logic [33:0] dmi_resp_i;

  dmi_initiator #(.TimeoutCycles(8), .CntWidth(16)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .update_i         (update_i),
    .update_addr_i    (update_addr_i),
    .update_op_i      (update_op_i),
    .update_data_i    (update_data_i),
    .dmireset_i       (dmireset_i),
    .dmihardreset_i   (dmihardreset_i),
    .capture_addr_o   (capture_addr_o),
    .capture_data_o   (capture_data_o),
    .capture_status_o (capture_status_o),
    .busy_o           (busy_o),
    .dmi_req_valid_o  (dmi_req_valid_o),
    .dmi_req_ready_i  (dmi_req_ready_i),
    .dmi_req_o        (dmi_req_o),
    .dmi_resp_valid_i (dmi_resp_valid_i),
    .dmi_resp_ready_o (dmi_resp_ready_o),
    .dmi_resp_i       (dmi_resp_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  status;
    logic [6:0]  addr;
  } done_t;

  logic [40:0] exp_req_q[$];
  done_t       exp_done_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [1:0]  model_sticky = 2'd0;
  logic [31:0] last_data    = 32'd0;
  logic [6:0]  last_addr    = 7'd0;
  logic [31:0] mem [128];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: requests are compared at handshake, completions when busy falls.
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (!rst_i) begin
      if (dmi_req_valid_o && dmi_req_ready_i) begin
        if (exp_req_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_req: got %0h expected none", dmi_req_o);
        end else begin
          check("req_word", 64'(dmi_req_o), 64'(exp_req_q.pop_front()));
        end
      end
      if (prev_busy && !busy_o) begin
        if (exp_done_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done: got data %0h expected none", capture_data_o);
        end else begin
          done_t e;
          e = exp_done_q.pop_front();
          check("done_data",   64'(capture_data_o),   64'(e.data));
          check("done_status", 64'(capture_status_o), 64'(e.status));
          check("done_addr",   64'(capture_addr_o),   64'(e.addr));
        end
      end
    end
    prev_busy = busy_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic update_pulse(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data);
    update_i = 1'b1; update_op_i = op; update_addr_i = addr; update_data_i = data;
    tick();
    update_i = 1'b0;
  endtask

  task automatic model_cmd(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                           output bit issued);
    issued = (model_sticky == 2'd0) && (op == 2'd1 || op == 2'd2);
    if (issued) begin
      exp_req_q.push_back({addr, data, op});
      last_addr = addr;
    end
  endtask

  task automatic dmireset_pulse();
    dmireset_i = 1'b1;
    tick();
    dmireset_i = 1'b0;
    model_sticky = 2'd0;
    check("status_after_dmireset", 64'(capture_status_o), 64'd0);
  endtask

  task automatic full_txn(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wdata,
                          input int rdy_dly, input int rsp_dly, input bit viol,
                          input logic [1:0] code, input logic [31:0] rdata);
    bit issued;
    model_cmd(op, addr, wdata, issued);
    update_pulse(op, addr, wdata);
    if (!issued) begin
      check("ignored_busy",   64'(busy_o),           64'd0);
      check("ignored_status", 64'(capture_status_o), 64'(model_sticky));
    end else begin
      check("req_valid",   64'(dmi_req_valid_o),  64'd1);
      check("status_busy", 64'(capture_status_o), 64'd3);
      repeat (rdy_dly) tick();
      dmi_req_ready_i = 1'b1;
      tick();
      dmi_req_ready_i = 1'b0;
      check("resp_ready_wait", 64'(dmi_resp_ready_o), 64'd1);
      if (viol) begin
        update_pulse(2'(op + 2'd1), 7'(addr + 7'd1), ~wdata);
        if (model_sticky == 2'd0) model_sticky = 2'd3;
      end
      repeat (rsp_dly) tick();
      dmi_resp_valid_i = 1'b1;
      dmi_resp_i = {rdata, code};
      if (code[1]) model_sticky = code;
      last_data = rdata;
      exp_done_q.push_back({rdata, model_sticky, last_addr});
      tick();
      dmi_resp_valid_i = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit issued;
    int k;
    for (int i = 0; i < 128; i++) mem[i] = 32'd0;
    rst_i = 1'b1; update_i = 1'b0; update_addr_i = '0; update_op_i = '0; update_data_i = '0;
    dmireset_i = 1'b0; dmihardreset_i = 1'b0; dmi_req_ready_i = 1'b0;
    dmi_resp_valid_i = 1'b0; dmi_resp_i = '0;
    repeat (3) tick();
    check("rst_busy",       64'(busy_o),           64'd0);
    check("rst_req_valid",  64'(dmi_req_valid_o),  64'd0);
    check("rst_resp_ready", 64'(dmi_resp_ready_o), 64'd1);
    check("rst_status",     64'(capture_status_o), 64'd0);
    check("rst_cap_data",   64'(capture_data_o),   64'd0);
    check("rst_req",        64'(dmi_req_o),        64'd0);
    rst_i = 1'b0;
    tick();

    // Write then read
    full_txn(2'd2, 7'h10, 32'h0000_0001, 2, 1, 1'b0, 2'd0, 32'h0);
    full_txn(2'd1, 7'h11, 32'h0, 0, 0, 1'b0, 2'd0, 32'hDEAD_BEEF);
    tick();
    check("rd_cap_data", 64'(capture_data_o),   64'hDEAD_BEEF);
    check("rd_status",   64'(capture_status_o), 64'd0);
    check("rd_busy",     64'(busy_o),           64'd0);

    // Nop and reserved ops issue nothing
    full_txn(2'd0, 7'h12, 32'h1, 0, 0, 1'b0, 2'd0, 32'h0);
    full_txn(2'd3, 7'h13, 32'h1, 0, 0, 1'b0, 2'd0, 32'h0);

    // Busy violation, ignored update, dmireset, then recovery
    full_txn(2'd1, 7'h20, 32'h0, 0, 2, 1'b1, 2'd0, 32'h55);
    full_txn(2'd1, 7'h21, 32'h0, 0, 0, 1'b0, 2'd0, 32'h0);
    dmireset_pulse();
    full_txn(2'd2, 7'h22, 32'hA5A5_0000, 1, 0, 1'b0, 2'd0, 32'h7);

    // dmireset in the same cycle as an update suppresses the update
    dmireset_i = 1'b1;
    update_pulse(2'd1, 7'h23, 32'h0);
    dmireset_i = 1'b0;
    check("dmireset_blocks_update", 64'(busy_o), 64'd0);

    // Error response
    full_txn(2'd1, 7'h30, 32'h0, 1, 1, 1'b0, 2'd2, 32'h1234_5678);
    tick();
    check("err_cap_data", 64'(capture_data_o),   64'h1234_5678);
    check("err_status",   64'(capture_status_o), 64'd2);
    full_txn(2'd2, 7'h31, 32'h9, 0, 0, 1'b0, 2'd0, 32'h0);
    dmireset_pulse();

    // Timeout: no response, busy must drop 8 cycles after acceptance
    model_cmd(2'd1, 7'h40, 32'h0, issued);
    update_pulse(2'd1, 7'h40, 32'h0);
    dmi_req_ready_i = 1'b1;
    tick();
    dmi_req_ready_i = 1'b0;
    model_sticky = 2'd2;
    exp_done_q.push_back({last_data, 2'd2, last_addr});
    for (k = 1; k <= 20; k++) begin
      tick();
      if (!busy_o) break;
    end
    check("timeout_cycles", 64'(k), 64'd8);
    repeat (2) tick();
    check("late_resp_ready", 64'(dmi_resp_ready_o), 64'd1);
    dmi_resp_valid_i = 1'b1;
    dmi_resp_i = {32'hBAD0_BAD0, 2'd0};
    tick();
    dmi_resp_valid_i = 1'b0;
    check("late_cap_data", 64'(capture_data_o),   64'(last_data));
    check("late_status",   64'(capture_status_o), 64'd2);
    check("late_busy",     64'(busy_o),           64'd0);
    dmireset_pulse();

    // Hardreset while the request is pending
    model_cmd(2'd2, 7'h50, 32'hCAFE_F00D, issued);
    update_pulse(2'd2, 7'h50, 32'hCAFE_F00D);
    tick();
    check("hr_pre_valid", 64'(dmi_req_valid_o), 64'd1);
    dmihardreset_i = 1'b1;
    model_sticky = 2'd0;
    exp_done_q.push_back({last_data, 2'd0, last_addr});
    tick();
    dmihardreset_i = 1'b0;
    void'(exp_req_q.pop_back());
    check("hr_valid",  64'(dmi_req_valid_o),  64'd0);
    check("hr_busy",   64'(busy_o),           64'd0);
    check("hr_status", 64'(capture_status_o), 64'd0);
    tick();

    // Randomized traffic against the responder memory
    for (int it = 0; it < 40; it++) begin
      logic [1:0]  op;
      logic [6:0]  addr;
      logic [31:0] wdata, rdata;
      logic [1:0]  code;
      int rdy, rsp, r;
      bit viol;
      op    = 2'($urandom_range(0, 3));
      addr  = 7'($urandom);
      wdata = $urandom;
      rdy   = $urandom_range(0, 3);
      rsp   = $urandom_range(0, 4);
      viol  = ($urandom_range(0, 4) == 0);
      r     = $urandom_range(0, 9);
      code  = (r < 7) ? 2'd0 : ((r < 9) ? 2'd2 : 2'd3);
      rdata = (op == 2'd1) ? mem[addr] : $urandom;
      if (model_sticky == 2'd0 && op == 2'd2) mem[addr] = wdata;
      full_txn(op, addr, wdata, rdy, rsp, viol, code, rdata);
      if (model_sticky != 2'd0 && $urandom_range(0, 1) == 1) dmireset_pulse();
    end
    if (model_sticky != 2'd0) dmireset_pulse();

    // Asynchronous reset in the middle of a wait
    model_cmd(2'd1, 7'h60, 32'h0, issued);
    update_pulse(2'd1, 7'h60, 32'h0);
    dmi_req_ready_i = 1'b1;
    tick();
    dmi_req_ready_i = 1'b0;
    tick();
    #2 rst_i = 1'b1;
    #1;
    check("arst_busy",       64'(busy_o),           64'd0);
    check("arst_valid",      64'(dmi_req_valid_o),  64'd0);
    check("arst_resp_ready", 64'(dmi_resp_ready_o), 64'd1);
    check("arst_status",     64'(capture_status_o), 64'd0);
    check("arst_cap_data",   64'(capture_data_o),   64'd0);
    check("arst_cap_addr",   64'(capture_addr_o),   64'd0);
    repeat (2) tick();
    rst_i = 1'b0;
    model_sticky = 2'd0; last_data = 32'd0; last_addr = 7'd0;
    tick();

    check("req_queue_drained",  64'(exp_req_q.size()),  64'd0);
    check("done_queue_drained", 64'(exp_done_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmi_initiator.md
Name: dmi_initiator

Overview:
- DMI host-side initiator: converts DTM-style dmi register updates (addr/op/data) into DMI requests toward the debug module's DMI responder port, then collects the responses.
- Sits between the JTAG DTM shift/update logic (or any CDC'd host) and the debug module's dmi_req/dmi_resp handshakes.
- Holds one outstanding transaction, reports a sticky error status, supports dmireset/dmihardreset and an optional response timeout.

Parameters:
- TimeoutCycles, 0, cycles to wait for dmi_resp_valid_i after request acceptance; 0 disables the timeout.
- CntWidth, 16, width of timeout counter; TimeoutCycles must be < 2**CntWidth.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- update_i  in  1  single-cycle pulse: new dmi access presented
- update_addr_i  in  7  DMI address
- update_op_i  in  2  0 nop, 1 read, 2 write, 3 reserved (treated as nop)
- update_data_i  in  32  write data
- dmireset_i  in  1  pulse: clear sticky error
- dmihardreset_i  in  1  pulse: abort transaction and clear error
- capture_addr_o  out  7  address of last issued request
- capture_data_o  out  32  data of last completed response
- capture_status_o  out  2  0 ok, 2 failed, 3 busy
- busy_o  out  1  transaction outstanding (state != IDLE)
- dmi_req_valid_o  out  1  request valid
- dmi_req_ready_i  in  1  request accepted
- dmi_req_o  out  41  {addr[40:34], data[33:2], op[1:0]}
- dmi_resp_valid_i  in  1  response valid
- dmi_resp_ready_o  out  1  response accept
- dmi_resp_i  in  34  {data[33:2], resp[1:0]}; resp 0 ok, 2 failed, 3 busy

Behaviour:
- Reset (async, rst_i=1): state IDLE; all outputs 0 except dmi_resp_ready_o=1; sticky=0; counter=0.
- Status: capture_status_o = sticky if sticky≠0; else 3 if busy_o; else 0.
- dmi_resp_ready_o = 1 in IDLE and WAIT, 0 in REQ. A response arriving in IDLE (stray, e.g. after an abort or timeout) is accepted and discarded with no state or output change.
- IDLE:
  - update_i with op 1/2, sticky=0 and no dmireset/dmihardreset that cycle: register addr/data/op into dmi_req_o and capture_addr_o; go to REQ. dmi_req_valid_o is high the next cycle.
  - op 0/3: no request, no change.
  - sticky≠0: update ignored.
- REQ:
  - dmi_req_valid_o=1; dmi_req_o held stable.
  - On dmi_req_ready_i=1: go to WAIT, clear counter; valid drops the next cycle.
- WAIT:
  - Counter increments each cycle.
  - On dmi_resp_valid_i=1: capture_data_o ← resp data; sticky ← resp code if resp ∈ {2,3}, else unchanged; go to IDLE (busy_o low the next cycle).
  - Else if TimeoutCycles≠0 and counter == TimeoutCycles-1: sticky ← 2, go to IDLE, capture_data_o unchanged.
  - A response in the timeout-expiry cycle wins over the timeout.
- update_i while busy_o=1: sticky ← 3 if sticky==0; the command is dropped; the outstanding transaction continues.
- dmireset_i: sticky ← 0; any update_i in the same cycle is ignored; no effect on state.
- dmihardreset_i: sticky ← 0, state → IDLE, dmi_req_valid_o → 0 next cycle, counter cleared. It takes precedence over dmireset_i, update_i, handshakes and timeout. capture registers are kept.
- Sticky error priority within a cycle: hardreset > dmireset > response/timeout > busy-violation.
- Counter saturates at all-ones and does not wrap.

Test Plan:
- Write then read: update op=2 addr=0x10 data=0x00000001; ready after 2 cycles; resp ok. Then op=1 addr=0x11; resp {0xDEADBEEF,0}. Required: dmi_req_o=={0x10,0x00000001,2} while valid; capture_data_o==0xDEADBEEF, capture_status_o==0, busy_o==0 one cycle after resp.
- Busy violation: update during WAIT. Required: capture_status_o==3 after completion, no second request issued. Next update ignored until dmireset_i pulse; after dmireset_i, status==0 and a new update issues a request.
- Error response: resp code 2 with data 0x12345678. Required: status==2, capture_data_o==0x12345678, subsequent updates ignored.
- Timeout: TimeoutCycles=8, no response. Required: busy_o drops exactly 8 cycles after request acceptance, status==2. A late response 3 cycles later is accepted (resp_ready=1) and capture_data_o is unchanged.
- Hardreset mid-REQ: hold dmi_req_ready_i=0, pulse dmihardreset_i. Required: dmi_req_valid_o==0 and busy_o==0 next cycle, status==0.
- Async reset during WAIT: assert rst_i between clock edges. Required: outputs are reset values immediately, dmi_resp_ready_o==1.
